byte_stream_loader: RTL and testbench

//  Sequences byte_to_word to load a byte stream into word-wide memory. After a start

---
 rtl/byte_stream_loader_pkg.sv | 18 +
 rtl/byte_to_word.sv | 22 ++
 rtl/byte_stream_loader.sv | 121 ++++++++++++
 tb/tb_byte_stream_loader.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/byte_stream_loader_pkg.sv
// Shared types and helpers for the byte stream loader.
// Holds the FSM state encoding and the byte-lane decode.
package loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WRITE,
        DONE
    } loader_state_t;

    localparam int LANES = 4;

    function automatic logic [LANES-1:0] lane_onehot(input logic [1:0] lane);
        lane_onehot = 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/byte_to_word.sv
// Maps a byte address and byte value onto a word address,
// a one-hot lane enable and a lane-positioned 32-bit word.
module byte_to_word
    import loader_pkg::*;
#(
    parameter int BYTE_ADDR_WIDTH = 6
) (
    input  logic [BYTE_ADDR_WIDTH-1:0] byte_addr_in,
    input  logic [7:0]                 byte_data_in,
    output logic [BYTE_ADDR_WIDTH-3:0] word_addr_out,
    output logic [3:0]                 word_byte_en_out,
    output logic [31:0]                word_data_out
);

    logic [1:0] w_lane;

    assign w_lane           = byte_addr_in[1:0];
    assign word_addr_out    = byte_addr_in[BYTE_ADDR_WIDTH-1:2];
    assign word_byte_en_out = lane_onehot(w_lane);
    assign word_data_out    = {24'b0, byte_data_in} << {w_lane, 3'b000};

endmodule

// File: rtl/byte_stream_loader.sv
// Loads a valid/ready byte stream into word memory, merging
// consecutive bytes of one word into a single masked write.
module byte_stream_loader
    import loader_pkg::*;
#(
    parameter int BYTE_ADDR_WIDTH = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_in,
    input  logic [BYTE_ADDR_WIDTH-1:0] base_addr_in,
    input  logic [BYTE_ADDR_WIDTH:0]   len_in,
    input  logic                       byte_valid_in,
    input  logic [7:0]                 byte_data_in,
    output logic                       byte_ready_out,
    output logic                       mem_we_out,
    output logic [BYTE_ADDR_WIDTH-3:0] mem_addr_out,
    output logic [3:0]                 mem_byte_en_out,
    output logic [31:0]                mem_data_out,
    input  logic                       mem_ack_in,
    output logic                       busy_out,
    output logic                       done_out
);

    localparam int BAW = BYTE_ADDR_WIDTH;
    localparam int WAW = BYTE_ADDR_WIDTH - 2;
    localparam logic [BAW:0] LEN_ONE = (BAW+1)'(1);

    loader_state_t r_state;
    loader_state_t w_state_nxt;

    logic [BAW-1:0] r_cur_addr;
    logic [BAW:0]   r_remaining;
    logic [WAW-1:0] r_buf_waddr;
    logic [3:0]     r_buf_be;
    logic [31:0]    r_buf_data;

    logic [WAW-1:0] w_waddr;
    logic [3:0]     w_be;
    logic [31:0]    w_data;
    logic           w_hs;
    logic           w_flush;
    logic           w_ack;
    logic           w_start;

    byte_to_word #(
        .BYTE_ADDR_WIDTH(BAW)
    ) u_b2w (
        .byte_addr_in    (r_cur_addr),
        .byte_data_in    (byte_data_in),
        .word_addr_out   (w_waddr),
        .word_byte_en_out(w_be),
        .word_data_out   (w_data)
    );

    assign w_start = (r_state == IDLE) && start_in;
    assign w_hs    = byte_valid_in && (r_state == COLLECT);
    // Flush on the top lane so a word write never spans two words, even at wrap.
    assign w_flush = w_hs && (w_be[3] || (r_remaining == LEN_ONE));
    assign w_ack   = mem_ack_in && (r_state == WRITE);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (start_in) begin
                    w_state_nxt = (len_in == '0) ? DONE : COLLECT;
                end
            end
            COLLECT: begin
                if (w_flush) begin
                    w_state_nxt = WRITE;
                end
            end
            WRITE: begin
                if (mem_ack_in) begin
                    w_state_nxt = (r_remaining == '0) ? DONE : COLLECT;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cur_addr  <= '0;
            r_remaining <= '0;
            r_buf_waddr <= '0;
            r_buf_be    <= '0;
            r_buf_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_cur_addr  <= base_addr_in;
                r_remaining <= len_in;
            end
            if (w_hs) begin
                r_cur_addr  <= r_cur_addr + BAW'(1);
                r_remaining <= r_remaining - LEN_ONE;
                r_buf_waddr <= w_waddr;
                r_buf_be    <= r_buf_be | w_be;
                r_buf_data  <= r_buf_data | w_data;
            end
            if (w_ack) begin
                r_buf_be   <= '0;
                r_buf_data <= '0;
            end
        end
    end

    assign byte_ready_out  = (r_state == COLLECT);
    assign mem_we_out      = (r_state == WRITE);
    assign mem_addr_out    = r_buf_waddr;
    assign mem_byte_en_out = r_buf_be;
    assign mem_data_out    = r_buf_data;
    assign busy_out        = (r_state != IDLE);
    assign done_out        = (r_state == DONE);

endmodule

// File: tb/tb_byte_stream_loader.sv
// Randomized bench for byte_stream_loader with a queue-based
// model of the expected word writes and directed corner cases.
module tb_byte_stream_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_in;
    logic [5:0]  base_addr_in;
    logic [6:0]  len_in;
    logic        byte_valid_in;
    logic [7:0]  byte_data_in;
    logic        byte_ready_out;
    logic        mem_we_out;
    logic [3:0]  mem_addr_out;
    logic [3:0]  mem_byte_en_out;
    logic [31:0] mem_data_out;
    logic        mem_ack_in;
    logic        busy_out;
    logic        done_out;

    byte_stream_loader #(.BYTE_ADDR_WIDTH(6)) dut (
        .clk            (clk),
        .rst            (rst),
        .start_in       (start_in),
        .base_addr_in   (base_addr_in),
        .len_in         (len_in),
        .byte_valid_in  (byte_valid_in),
        .byte_data_in   (byte_data_in),
        .byte_ready_out (byte_ready_out),
        .mem_we_out     (mem_we_out),
        .mem_addr_out   (mem_addr_out),
        .mem_byte_en_out(mem_byte_en_out),
        .mem_data_out   (mem_data_out),
        .mem_ack_in     (mem_ack_in),
        .busy_out       (busy_out),
        .done_out       (done_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  addr;
        logic [3:0]  be;
        logic [31:0] data;
    } wr_t;

    int vectors = 0;
    int miscompares = 0;

    wr_t        exp_q[$];
    logic [7:0] byte_q[$];
    int send_idx = 0;
    int send_len = 0;
    int ack_mode = 0;
    int wcnt = 0;
    bit vrand = 1'b0;
    int writes_seen = 0;
    int dones_seen = 0;
    int cyc = 0;
    int last_ack = 0;
    logic        p_we = 1'b0;
    logic        p_ack = 1'b0;
    logic [3:0]  p_addr;
    logic [3:0]  p_be;
    logic [31:0] p_data;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected writes: walk the bytes in address order, one write per run of
    // consecutive bytes sharing a word address.
    task automatic model(input int base, input int len);
        wr_t w;
        bit  open;
        int  a;
        w    = '0;
        open = 1'b0;
        for (int i = 0; i < len; i++) begin
            a = (base + i) % 64;
            if (open && (int'(w.addr) != a / 4)) begin
                exp_q.push_back(w);
                open = 1'b0;
            end
            if (!open) begin
                w      = '0;
                w.addr = 4'(a / 4);
                open   = 1'b1;
            end
            w.be[a % 4]            = 1'b1;
            w.data[8*(a % 4) +: 8] = byte_q[i];
        end
        if (open) exp_q.push_back(w);
    endtask

    always @(posedge clk) begin
        #1;
        if (send_idx < send_len && (!vrand || $urandom_range(0, 3) != 0)) begin
            byte_valid_in = 1'b1;
            byte_data_in  = byte_q[send_idx];
        end else begin
            byte_valid_in = 1'b0;
            byte_data_in  = 8'($urandom);
        end
        case (ack_mode)
            0: mem_ack_in = 1'b1;
            1: mem_ack_in = 1'($urandom_range(0, 1));
            default: begin
                if (mem_we_out) begin
                    mem_ack_in = (wcnt >= 3);
                    wcnt       = mem_ack_in ? 0 : wcnt + 1;
                end else begin
                    mem_ack_in = 1'b0;
                    wcnt       = 0;
                end
            end
        endcase
    end

    always @(negedge clk) begin
        cyc++;
        if (rst !== 1'b0) begin
            p_we  = 1'b0;
            p_ack = 1'b0;
        end else begin
            if (byte_valid_in && byte_ready_out) begin
                if (send_idx >= send_len) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL extra_byte: got handshake expected none at %0t", $time);
                end else begin
                    send_idx++;
                end
            end
            if (mem_we_out) begin
                chk("ready_in_write", byte_ready_out, 0);
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_write: got addr %0h expected no write", mem_addr_out);
                end else begin
                    chk("wr_addr", mem_addr_out, exp_q[0].addr);
                    chk("wr_be", mem_byte_en_out, exp_q[0].be);
                    chk("wr_data", mem_data_out, exp_q[0].data);
                    if (mem_ack_in) begin
                        void'(exp_q.pop_front());
                        writes_seen++;
                        last_ack = cyc;
                    end
                end
                if (p_we && !p_ack) begin
                    chk("stable_addr", mem_addr_out, p_addr);
                    chk("stable_be", mem_byte_en_out, p_be);
                    chk("stable_data", mem_data_out, p_data);
                end
            end
            if (done_out) begin
                dones_seen++;
                chk("done_writes_left", exp_q.size(), 0);
                chk("done_bytes_sent", send_idx, send_len);
                if (send_len > 0) chk("done_after_ack", cyc - last_ack, 1);
            end
            p_we   = mem_we_out;
            p_ack  = mem_ack_in;
            p_addr = mem_addr_out;
            p_be   = mem_byte_en_out;
            p_data = mem_data_out;
        end
    end

    task automatic chk_all_zero();
        chk("rst_ready", byte_ready_out, 0);
        chk("rst_we", mem_we_out, 0);
        chk("rst_addr", mem_addr_out, 0);
        chk("rst_be", mem_byte_en_out, 0);
        chk("rst_data", mem_data_out, 0);
        chk("rst_busy", busy_out, 0);
        chk("rst_done", done_out, 0);
    endtask

    task automatic run(input int base, input int len, input int amode,
                       input bit vr, input bit spam, input bit given, input int rst_after);
        int n_exp;
        int c;
        if (!given) begin
            byte_q.delete();
            for (int i = 0; i < len; i++) byte_q.push_back(8'($urandom));
        end
        exp_q.delete();
        model(base, len);
        n_exp       = exp_q.size();
        writes_seen = 0;
        dones_seen  = 0;
        ack_mode    = amode;
        vrand       = vr;
        @(posedge clk);
        #1;
        send_idx     = 0;
        send_len     = len;
        start_in     = 1'b1;
        base_addr_in = 6'(base);
        len_in       = 7'(len);
        @(posedge clk);
        #1;
        start_in = 1'b0;
        chk("busy_after_start", busy_out, 1);
        if (len == 0) chk("len0_done_next", done_out, 1);
        c = 0;
        while (!done_out && c < 2000) begin
            if (rst_after > 0 && send_idx >= rst_after) begin
                rst      = 1'b1;
                send_len = 0;
                @(posedge clk);
                #1;
                rst = 1'b0;
                chk_all_zero();
                repeat (4) begin
                    @(posedge clk);
                    #1;
                    chk("post_rst_we", mem_we_out, 0);
                    chk("post_rst_done", done_out, 0);
                end
                chk("post_rst_writes", writes_seen, 0);
                chk("post_rst_dones", dones_seen, 0);
                exp_q.delete();
                return;
            end
            start_in     = spam ? 1'($urandom_range(0, 1)) : 1'b0;
            base_addr_in = 6'($urandom);
            len_in       = 7'($urandom_range(0, 64));
            @(posedge clk);
            #1;
            c++;
        end
        start_in = 1'b0;
        if (c >= 2000) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: got no done expected done within 2000 cycles");
        end
        @(posedge clk);
        #1;
        chk("idle_busy", busy_out, 0);
        chk("idle_done", done_out, 0);
        chk("done_count", dones_seen, 1);
        chk("write_count", writes_seen, n_exp);
        chk("writes_left", exp_q.size(), 0);
    endtask

    initial begin
        rst           = 1'b1;
        start_in      = 1'b0;
        base_addr_in  = '0;
        len_in        = '0;
        byte_valid_in = 1'b0;
        byte_data_in  = '0;
        mem_ack_in    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero();
        rst = 1'b0;

        byte_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_q.delete();
        model(0, 4);
        chk("m1_n", exp_q.size(), 1);
        chk("m1_w0", exp_q[0], {4'd0, 4'b1111, 32'h44332211});
        run(0, 4, 0, 1'b0, 1'b0, 1'b1, 0);

        byte_q = '{8'hAA, 8'hBB, 8'hCC};
        exp_q.delete();
        model(2, 3);
        chk("m2_n", exp_q.size(), 2);
        chk("m2_w0", exp_q[0], {4'd0, 4'b1100, 32'hBBAA0000});
        chk("m2_w1", exp_q[1], {4'd1, 4'b0001, 32'h000000CC});
        run(2, 3, 1, 1'b0, 1'b0, 1'b1, 0);

        run(17, 0, 0, 1'b0, 1'b0, 1'b0, 0);

        byte_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        exp_q.delete();
        model(62, 4);
        chk("m4_n", exp_q.size(), 2);
        chk("m4_w0", exp_q[0], {4'd15, 4'b1100, 32'h02010000});
        chk("m4_w1", exp_q[1], {4'd0, 4'b0011, 32'h00000403});
        run(62, 4, 0, 1'b0, 1'b0, 1'b1, 0);

        run(9, 1, 2, 1'b0, 1'b1, 1'b0, 0);
        run(0, 4, 0, 1'b0, 1'b0, 1'b0, 2);
        run(0, 1, 0, 1'b0, 1'b0, 1'b0, 0);
        run(5, 64, 1, 1'b1, 1'b1, 1'b0, 0);

        for (int t = 0; t < 30; t++) begin
            run(int'($urandom_range(0, 63)), int'($urandom_range(0, 64)),
                int'($urandom_range(0, 2)), 1'b1, 1'($urandom_range(0, 1)), 1'b0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
